// File: rtl/writeback_unit_pkg.sv
// Shared constants and slot layout for the in-order writeback buffer.
// Imported by the buffer top and its pending-match helper.
package writeback_unit_pkg;

  localparam int WB_DEPTH = 8;
  localparam int WB_TAGW  = $clog2(WB_DEPTH);

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [1:0]  rw;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_slot_t;

endpackage

// File: rtl/writeback_unit_pending_match.sv
// Compares one {fpr_bit, index} operand id against every occupied slot.
// Done-but-unretired slots still report pending.
module wb_pending_match
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  wb_slot_t   i_slots [DEPTH],
  input  logic [5:0] i_q,
  output logic       o_pending
);

  logic [DEPTH-1:0] w_hit;
  logic [1:0]       w_kind;

  assign w_kind = i_q[5] ? RW_FPR : RW_GPR;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit[i] = i_slots[i].valid
              && (i_slots[i].rw == w_kind)
              && (i_slots[i].rd == i_q[4:0]);
    end
  end

  assign o_pending = |w_hit;

endmodule

// File: rtl/writeback_unit.sv
// In-order completion buffer: allocates slots at issue, collects late
// results, retires one register write per cycle in program order.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int TAGW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            issue_valid,
  output logic            issue_ready,
  output logic [TAGW-1:0] issue_tag,
  input  logic [1:0]      issue_rw,
  input  logic [4:0]      issue_rd,
  input  logic            issue_done,
  input  logic [31:0]     issue_data,
  input  logic            res_valid,
  input  logic [TAGW-1:0] res_tag,
  input  logic [31:0]     res_data,
  input  logic [5:0]      qs,
  input  logic [5:0]      qt,
  output logic            s_pending,
  output logic            t_pending,
  output logic [1:0]      rwout,
  output logic [4:0]      rdout,
  output logic [31:0]     dtowrite,
  output logic            empty
);

  localparam logic [TAGW:0]   L_FULL = (TAGW+1)'(DEPTH);
  localparam logic [TAGW:0]   L_CONE = (TAGW+1)'(1);
  localparam logic [TAGW-1:0] L_PONE = TAGW'(1);

  wb_slot_t        r_slots [DEPTH];
  logic [TAGW-1:0] r_head;
  logic [TAGW-1:0] r_tail;
  logic [TAGW:0]   r_count;
  logic [1:0]      r_rwout;
  logic [4:0]      r_rdout;
  logic [31:0]     r_data;

  wb_slot_t w_head;
  wb_slot_t w_rslot;
  logic     w_issue;
  logic     w_res;
  logic     w_retire;

  assign w_head   = r_slots[r_head];
  assign w_rslot  = r_slots[res_tag];
  assign w_issue  = issue_valid && issue_ready;
  assign w_res    = res_valid && w_rslot.valid && !w_rslot.done;
  assign w_retire = w_head.valid && w_head.done;

  assign issue_ready = (r_count != L_FULL);
  assign issue_tag   = r_tail;
  assign empty       = (r_count == '0);
  assign rwout       = r_rwout;
  assign rdout       = r_rdout;
  assign dtowrite    = r_data;

  // Issue, result and retire never hit the same slot in one cycle:
  // the tail slot is free, and only not-done slots accept results.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slots[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_issue && r_tail == TAGW'(i)) begin
          r_slots[i] <= '{valid: 1'b1,
                          done:  issue_done,
                          rw:    issue_rw,
                          rd:    issue_rd,
                          data:  issue_data};
        end else if (w_res && res_tag == TAGW'(i)) begin
          r_slots[i].done <= 1'b1;
          r_slots[i].data <= res_data;
        end else if (w_retire && r_head == TAGW'(i)) begin
          r_slots[i].valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rwout <= RW_NONE;
      r_rdout <= '0;
      r_data  <= '0;
    end else begin
      if (w_issue) begin
        r_tail <= r_tail + L_PONE;
      end
      if (w_retire) begin
        r_head  <= r_head + L_PONE;
        r_rwout <= w_head.rw;
        r_rdout <= w_head.rd;
        r_data  <= w_head.data;
      end else begin
        r_rwout <= RW_NONE;
      end
      case ({w_issue, w_retire})
        2'b10:   r_count <= r_count + L_CONE;
        2'b01:   r_count <= r_count - L_CONE;
        default: r_count <= r_count;
      endcase
    end
  end

  wb_pending_match #(.DEPTH(DEPTH)) u_match_s (
    .i_slots   (r_slots),
    .i_q       (qs),
    .o_pending (s_pending)
  );

  wb_pending_match #(.DEPTH(DEPTH)) u_match_t (
    .i_slots   (r_slots),
    .i_q       (qt),
    .o_pending (t_pending)
  );

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: program-order queue of issued
// instructions, monitor pops and compares every register write.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic [1:0]  issue_rw = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_done = 1'b0;
  logic [31:0] issue_data = '0;
  logic        res_valid = 1'b0;
  logic [2:0]  res_tag = '0;
  logic [31:0] res_data = '0;
  logic [5:0]  qs = '0;
  logic [5:0]  qt = '0;
  logic        s_pending;
  logic        t_pending;
  logic [1:0]  rwout;
  logic [4:0]  rdout;
  logic [31:0] dtowrite;
  logic        empty;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_tag   (issue_tag),
    .issue_rw    (issue_rw),
    .issue_rd    (issue_rd),
    .issue_done  (issue_done),
    .issue_data  (issue_data),
    .res_valid   (res_valid),
    .res_tag     (res_tag),
    .res_data    (res_data),
    .qs          (qs),
    .qt          (qt),
    .s_pending   (s_pending),
    .t_pending   (t_pending),
    .rwout       (rwout),
    .rdout       (rdout),
    .dtowrite    (dtowrite),
    .empty       (empty)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: instructions in program order, indexed by sequence id
  int          q[$];
  logic [1:0]  m_rw   [4096];
  logic [4:0]  m_rd   [4096];
  logic [31:0] m_data [4096];
  bit          m_done [4096];
  int          m_tag  [4096];
  int          tag2seq[8];
  int          nseq = 0;
  int          mtail = 0;

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit m_pend(logic [5:0] id);
    logic [1:0] k;
    k = id[5] ? 2'b10 : 2'b01;
    foreach (q[i]) begin
      if (m_rw[q[i]] == k && m_rd[q[i]] == id[4:0]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit has_none();
    foreach (q[i]) if (m_rw[q[i]] == 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    q.delete();
    mtail = 0;
    for (int i = 0; i < 8; i++) tag2seq[i] = -1;
  endfunction

  always @(negedge clk) begin : mon
    int s;
    if (rstn) begin
      if (rwout != 2'b00) begin
        while (q.size() > 0 && m_rw[q[0]] == 2'b00) void'(q.pop_front());
        if (q.size() == 0) begin
          check("spurious_write", {30'd0, rwout}, 32'd0);
        end else begin
          s = q.pop_front();
          check("wr_done", {31'd0, m_done[s]}, 32'd1);
          check("wr_rw", {30'd0, rwout}, {30'd0, m_rw[s]});
          check("wr_rd", {27'd0, rdout}, {27'd0, m_rd[s]});
          check("wr_data", dtowrite, m_data[s]);
        end
      end
      check("s_pending", {31'd0, s_pending}, {31'd0, m_pend(qs)});
      check("t_pending", {31'd0, t_pending}, {31'd0, m_pend(qt)});
    end
  end

  task automatic cyc(bit iv, logic [1:0] rw, logic [4:0] rd, bit dn,
                     logic [31:0] d, bit rv, logic [2:0] rt,
                     logic [31:0] rdat, logic [5:0] a, logic [5:0] b);
    int s;
    @(negedge clk);
    #1;
    if (rstn) begin
      check("issue_tag", {29'd0, issue_tag}, mtail);
      if (!has_none()) begin
        check("issue_ready", {31'd0, issue_ready},
              {31'd0, q.size() < 8});
        check("empty", {31'd0, empty}, {31'd0, q.size() == 0});
      end
    end
    issue_valid = iv; issue_rw = rw; issue_rd = rd;
    issue_done = dn; issue_data = d;
    res_valid = rv; res_tag = rt; res_data = rdat;
    qs = a; qt = b;
    if (rstn && rv) begin
      s = tag2seq[rt];
      if (s >= 0 && !m_done[s]) begin
        m_done[s] = 1'b1;
        m_data[s] = rdat;
      end
    end
    if (rstn && iv && issue_ready) begin
      m_rw[nseq] = rw; m_rd[nseq] = rd; m_done[nseq] = dn;
      m_data[nseq] = dn ? d : 32'd0;
      m_tag[nseq] = mtail;
      tag2seq[mtail] = nseq;
      q.push_back(nseq);
      nseq++;
      mtail = (mtail + 1) % 8;
    end
  endtask

  task automatic idle();
    cyc(0, 2'b00, 5'd0, 0, 32'd0, 0, 3'd0, 32'd0, qs, qt);
  endtask

  task automatic ret(int s, logic [31:0] v);
    cyc(0, 2'b00, 5'd0, 0, 32'd0, 1, 3'(m_tag[s]), v, qs, qt);
  endtask

  task automatic drain();
    int  cand;
    bit  fin;
    fin = 1'b0;
    for (int n = 0; n < 300 && !fin; n++) begin
      cand = -1;
      foreach (q[i]) if (cand < 0 && !m_done[q[i]]) cand = q[i];
      if (cand >= 0) ret(cand, $urandom);
      else idle();
      if (cand < 0 && !has_none() && q.size() == 0 && empty) fin = 1'b1;
      if (cand < 0 && has_none() && empty) begin
        fin = 1'b1;
        foreach (q[i]) if (m_rw[q[i]] != 2'b00) fin = 1'b0;
      end
    end
    check("drain_done", {31'd0, fin}, 32'd1);
    q.delete();
  endtask

  task automatic reset_checks();
    check("rst_rwout", {30'd0, rwout}, 32'd0);
    check("rst_rdout", {27'd0, rdout}, 32'd0);
    check("rst_data", dtowrite, 32'd0);
    check("rst_ready", {31'd0, issue_ready}, 32'd1);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_spend", {31'd0, s_pending}, 32'd0);
    check("rst_tpend", {31'd0, t_pending}, 32'd0);
    check("rst_tag", {29'd0, issue_tag}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int cand[$];
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    reset_checks();
    rstn = 1'b1;

    // Single done-at-issue write, exact latency and one-cycle pulse
    cyc(1, 2'b01, 5'd5, 1, 32'h1234, 0, 3'd0, 32'd0, 6'h00, 6'h00);
    idle();
    check("lat_early", {30'd0, rwout}, 32'd0);
    idle();
    check("lat_rw", {30'd0, rwout}, 32'd1);
    check("lat_rd", {27'd0, rdout}, 32'd5);
    check("lat_data", dtowrite, 32'h1234);
    idle();
    check("pulse_rw", {30'd0, rwout}, 32'd0);
    check("pulse_empty", {31'd0, empty}, 32'd1);

    // Out-of-order result return, in-order retirement
    cyc(1, 2'b10, 5'd3, 0, 32'd0, 0, 3'd0, 32'd0, 6'h23, 6'h03);
    s0 = q[0];
    cyc(1, 2'b01, 5'd4, 1, 32'd7, 0, 3'd0, 32'd0, 6'h23, 6'h03);
    #1;
    check("qs_fpr3", {31'd0, s_pending}, 32'd1);
    check("qt_gpr3", {31'd0, t_pending}, 32'd0);
    cyc(0, 2'b00, 5'd0, 0, 32'd0, 1, 3'd2, 32'h99, 6'h23, 6'h04);
    idle();
    idle();
    check("hold_rw", {30'd0, rwout}, 32'd0);
    ret(s0, 32'h3fc00000);
    idle();
    idle();
    check("fpr3_rw", {30'd0, rwout}, 32'd2);
    check("fpr3_data", dtowrite, 32'h3fc00000);
    idle();
    check("gpr4_rw", {30'd0, rwout}, 32'd1);
    check("gpr4_data", dtowrite, 32'd7);
    idle();

    // Fill the buffer, overflow attempt, wrap-around of the tail
    for (int i = 0; i < 8; i++) begin
      cyc(1, 2'b01, 5'(i + 8), 0, 32'd0, 0, 3'd0, 32'd0,
          6'(i + 8), 6'h08);
    end
    idle();
    check("full_ready", {31'd0, issue_ready}, 32'd0);
    cyc(1, 2'b01, 5'd30, 1, 32'hdead, 0, 3'd0, 32'd0, 6'h1e, 6'h08);
    check("full_count", q.size(), 32'd8);
    ret(q[0], 32'hbeef);
    idle();
    idle();
    check("ready_back", {31'd0, issue_ready}, 32'd1);
    cyc(1, 2'b10, 5'd1, 1, 32'h55, 0, 3'd0, 32'd0, 6'h21, 6'h09);
    drain();

    // Asynchronous reset with outstanding slots
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'b01, 5'(i), 0, 32'd0, 0, 3'd0, 32'd0, 6'h01, 6'h02);
    end
    @(negedge clk);
    #1;
    rstn = 1'b0;
    issue_valid = 1'b0;
    model_reset();
    #2;
    reset_checks();
    @(negedge clk);
    #1;
    rstn = 1'b1;
    cyc(0, 2'b00, 5'd0, 0, 32'd0, 1, 3'd1, 32'h77, 6'h01, 6'h02);
    idle();
    idle();
    check("post_rst_rw", {30'd0, rwout}, 32'd0);
    check("post_rst_empty", {31'd0, empty}, 32'd1);

    // Non-writing slot between two writes costs one bubble
    cyc(1, 2'b01, 5'd7, 1, 32'h70, 0, 3'd0, 32'd0, 6'h07, 6'h08);
    cyc(1, 2'b00, 5'd9, 1, 32'h90, 0, 3'd0, 32'd0, 6'h07, 6'h08);
    check("bub_0", {30'd0, rwout}, 32'd0);
    cyc(1, 2'b01, 5'd8, 1, 32'h80, 0, 3'd0, 32'd0, 6'h07, 6'h08);
    check("bub_w1", {27'd0, rdout}, 32'd7);
    idle();
    check("bub_gap", {30'd0, rwout}, 32'd0);
    idle();
    check("bub_w2_rw", {30'd0, rwout}, 32'd1);
    check("bub_w2_rd", {27'd0, rdout}, 32'd8);
    drain();

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [1:0]  rw;
      bit          rv;
      logic [2:0]  rt;
      int          k;
      k  = $urandom_range(0, 7);
      rw = (k == 0) ? 2'b00 : (k < 4 ? 2'b01 : 2'b10);
      cand.delete();
      foreach (q[i]) if (!m_done[q[i]]) cand.push_back(q[i]);
      rv = 1'b0;
      rt = 3'd0;
      if (cand.size() > 0 && $urandom_range(0, 9) < 4) begin
        rv = 1'b1;
        rt = 3'(m_tag[cand[$urandom_range(0, cand.size() - 1)]]);
      end else if ($urandom_range(0, 9) == 0) begin
        rt = 3'($urandom_range(0, 7));
        rv = (tag2seq[rt] < 0) || m_done[tag2seq[rt]];
      end
      cyc($urandom_range(0, 9) < 6, rw, 5'($urandom_range(0, 7)),
          $urandom_range(0, 1) == 1, $urandom, rv, rt, $urandom,
          6'({$urandom_range(0, 1), 5'($urandom_range(0, 7))}),
          6'({$urandom_range(0, 1), 5'($urandom_range(0, 7))}));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
